// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C byte-level bit controller.
//   - command encodings presented on the cmd port
//   - controller FSM state enum
//   - quarter-period phase constants and the bits-per-byte-transfer count
// ----------------------------------------------------------------------------
package i2c_pkg;

    localparam logic [1:0] I2C_CMD_START = 2'b00;
    localparam logic [1:0] I2C_CMD_STOP  = 2'b01;
    localparam logic [1:0] I2C_CMD_WRITE = 2'b10;
    localparam logic [1:0] I2C_CMD_READ  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BIT   = 2'd2,
        ST_STOP  = 2'd3
    } i2c_state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // 8 data bits plus the acknowledge slot
    localparam int unsigned I2C_NBITS    = 9;
    localparam logic [3:0]  I2C_LAST_BIT = 4'(I2C_NBITS - 1);

endpackage

// File: rtl/i2c_bit_controller_if.sv
// ----------------------------------------------------------------------------
// i2c_bit_controller_if
// Command handshake, result and pad signals of the I2C bit controller.
//   master : core control FSM + pad side (issues commands, returns pad levels)
//   slave  : the bit controller itself
// Signals: cmd_valid/cmd_ready/cmd/wr_data/rd_ack_in (command),
//          rd_data/ack_out/done/busy/timeout_err (result),
//          scl_in/sda_in (pad levels), scl_oe/sda_oe (1 = pull line low).
// ----------------------------------------------------------------------------
interface i2c_bit_controller_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] wr_data;
    logic       rd_ack_in;
    logic [7:0] rd_data;
    logic       ack_out;
    logic       done;
    logic       busy;
    logic       timeout_err;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;

    modport master (
        output cmd_valid, cmd, wr_data, rd_ack_in, scl_in, sda_in,
        input  cmd_ready, rd_data, ack_out, done, busy, timeout_err, scl_oe, sda_oe
    );

    modport slave (
        input  cmd_valid, cmd, wr_data, rd_ack_in, scl_in, sda_in,
        output cmd_ready, rd_data, ack_out, done, busy, timeout_err, scl_oe, sda_oe
    );

endinterface

// File: rtl/i2c_shift_reg.sv
// ----------------------------------------------------------------------------
// i2c_shift_reg
// Byte shift register shared by WRITE and READ: loaded with the write byte,
// shifted left once per data bit with the sampled SDA level entering at the
// LSB. The MSB tap is the next bit to drive; after eight shifts q holds the
// received byte.
// Ports: clk, load/load_data (parallel load), shift_en/shift_in (shift left),
//        q (register contents), msb (q[DATA_W-1]).
// ----------------------------------------------------------------------------
module i2c_shift_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift_en,
    input  logic              shift_in,
    output logic [DATA_W-1:0] q,
    output logic              msb
);

    logic [DATA_W-1:0] sr;

    always_ff @(posedge clk) begin
        if (load) begin
            sr <= load_data;
        end else if (shift_en) begin
            sr <= {sr[DATA_W-2:0], shift_in};
        end
    end

    assign q   = sr;
    assign msb = sr[DATA_W-1];

endmodule

// File: rtl/i2c_bit_controller.sv
// ----------------------------------------------------------------------------
// i2c_bit_controller
// Byte-level I2C master bus sequencer. Executes START, STOP, WRITE-byte and
// READ-byte commands one at a time, stepping through four quarter-period
// phases per SCL period on the tick strobe, and drives the open-drain pads.
// Ports: clk, reset (sync, active-high), tick (quarter-period strobe),
//        bus (i2c_bit_controller_if.slave: handshake, results, pads).
// Build option: define CLK_STRETCH_EN to let a slave stretch SCL in the
// high phase of BIT/STOP, with an abort after STRETCH_TIMEOUT stalled ticks.
// ----------------------------------------------------------------------------
module i2c_bit_controller
    import i2c_pkg::*;
#(
    parameter int unsigned STRETCH_TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    i2c_bit_controller_if.slave        bus
);

    i2c_state_e state, state_n;
    logic [1:0] phase, phase_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic       scl_oe_q, sda_oe_q, scl_oe_n, sda_oe_n;
    logic       done_q, done_n;
    logic [7:0] rd_data_q;
    logic       ack_out_q;
    logic       is_read, rd_ack_q, ack_bit;
    logic       accept, advance, last_phase, stall, abort;
    logic       shift_en, ack_cap, publish;
    logic [7:0] sr_q;
    logic       sr_msb;

    assign accept     = bus.cmd_valid && (state == ST_IDLE);
    assign advance    = tick && (state != ST_IDLE) && !stall;
    assign last_phase = (phase == Q3) && ((state != ST_BIT) || (bit_cnt == I2C_LAST_BIT));

`ifdef CLK_STRETCH_EN
    localparam int unsigned STALL_W = $clog2(STRETCH_TIMEOUT + 1);
    logic [STALL_W-1:0] stall_cnt;
    logic               tmo_q;

    // Only the SCL-high phase can be stretched: the slave holds the line low
    // after the master released it.
    assign stall = tick && (phase == Q2) && ((state == ST_BIT) || (state == ST_STOP))
                   && !bus.scl_in;
    assign abort = stall && (stall_cnt == STALL_W'(STRETCH_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || accept || advance || abort) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
        if (reset) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= abort;
        end
    end

    assign bus.timeout_err = tmo_q;
`else
    logic unused_cfg;

    assign stall           = 1'b0;
    assign abort           = 1'b0;
    assign bus.timeout_err = 1'b0;
    assign unused_cfg      = ^{bus.scl_in, 32'(STRETCH_TIMEOUT)};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            phase     <= Q0;
            bit_cnt   <= '0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            ack_out_q <= 1'b1;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            bit_cnt  <= bit_cnt_n;
            scl_oe_q <= scl_oe_n;
            sda_oe_q <= sda_oe_n;
            done_q   <= done_n;
            if (publish) begin
                if (is_read) begin
                    rd_data_q <= sr_q;
                end else begin
                    ack_out_q <= ack_bit;
                end
            end
        end
    end

    // Command operands and the ack slot sample; meaningful only while busy
    always_ff @(posedge clk) begin
        if (accept) begin
            is_read  <= bus.cmd[0];
            rd_ack_q <= bus.rd_ack_in;
        end
        if (ack_cap) begin
            ack_bit <= bus.sda_in;
        end
    end

    // Next-state logic
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        bit_cnt_n = bit_cnt;
        if (state == ST_IDLE) begin
            if (bus.cmd_valid) begin
                phase_n   = Q0;
                bit_cnt_n = '0;
                case (bus.cmd)
                    I2C_CMD_START: state_n = ST_START;
                    I2C_CMD_STOP:  state_n = ST_STOP;
                    default:       state_n = ST_BIT;
                endcase
            end
        end else if (abort) begin
            state_n = ST_IDLE;
        end else if (advance) begin
            phase_n = phase + 2'd1;
            if (phase == Q3) begin
                bit_cnt_n = bit_cnt + 4'd1;
            end
            if (last_phase) begin
                state_n = ST_IDLE;
            end
        end
    end

    // Output logic: each phase action takes effect on the tick that ends it;
    // pad enables hold their value between ticks and while idle.
    always_comb begin
        scl_oe_n = scl_oe_q;
        sda_oe_n = sda_oe_q;
        shift_en = 1'b0;
        ack_cap  = 1'b0;
        publish  = 1'b0;
        done_n   = abort || (advance && last_phase);
        if (abort) begin
            scl_oe_n = 1'b0;
            sda_oe_n = 1'b0;
        end else if (advance) begin
            case (state)
                ST_START: begin
                    case (phase)
                        Q0: begin
                            scl_oe_n = 1'b0;
                            sda_oe_n = 1'b0;
                        end
                        Q1:      sda_oe_n = 1'b1;
                        Q3:      scl_oe_n = 1'b1;
                        default: ;
                    endcase
                end
                ST_BIT: begin
                    case (phase)
                        Q0: begin
                            scl_oe_n = 1'b1;
                            if (bit_cnt == I2C_LAST_BIT) begin
                                sda_oe_n = is_read ? !rd_ack_q : 1'b0;
                            end else begin
                                sda_oe_n = is_read ? 1'b0 : !sr_msb;
                            end
                        end
                        Q1: scl_oe_n = 1'b0;
                        Q2: begin
                            if (bit_cnt == I2C_LAST_BIT) begin
                                ack_cap = 1'b1;
                            end else begin
                                shift_en = 1'b1;
                            end
                        end
                        default: begin
                            scl_oe_n = 1'b1;
                            publish  = last_phase;
                        end
                    endcase
                end
                ST_STOP: begin
                    case (phase)
                        Q0: begin
                            scl_oe_n = 1'b1;
                            sda_oe_n = 1'b1;
                        end
                        Q1:      scl_oe_n = 1'b0;
                        Q2:      sda_oe_n = 1'b0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    i2c_shift_reg #(
        .DATA_W (8)
    ) u_shift (
        .clk       (clk),
        .load      (accept),
        .load_data (bus.wr_data),
        .shift_en  (shift_en),
        .shift_in  (bus.sda_in),
        .q         (sr_q),
        .msb       (sr_msb)
    );

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.ack_out   = ack_out_q;
    assign bus.scl_oe    = scl_oe_q;
    assign bus.sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_bit_controller.sv
// ----------------------------------------------------------------------------
// tb_i2c_bit_controller
// Table-driven bench for i2c_bit_controller with a pad/slave model and a
// scoreboard queue of expected command results.
// ----------------------------------------------------------------------------
module tb_i2c_bit_controller;
    import i2c_pkg::*;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] wr;
        logic       rack;
        logic [7:0] sbyte;
        logic       sack;
        int         spam;
        int         hold_bit;
        int         hold_ticks;
        logic [7:0] exp_rd;
        logic       exp_ack;
        logic       exp_tmo;
        int         exp_ticks;
        logic       exp_scl;
        logic       exp_sda;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;

    i2c_bit_controller_if bus ();

    i2c_bit_controller #(
        .STRETCH_TIMEOUT (1023)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pad / slave model
    logic       slave_sda = 1'b1;
    logic       hold_scl  = 1'b0;
    assign bus.scl_in = ~bus.scl_oe & ~hold_scl;
    assign bus.sda_in = ~bus.sda_oe & slave_sda;

    int         checks = 0;
    int         errors = 0;
    int         tphase = 0;
    int         tick_cnt = 0;
    logic       counting = 1'b0;
    int         done_cnt = 0;
    int         done_base = 0;
    logic       prev_scl = 1'b0;
    logic       prev_sda = 1'b0;
    logic       last_edge_scl = 1'b1;
    logic [8:0] mbits = '0;
    logic [8:0] sbits = '1;
    int         rise_cnt = 0;
    int         slave_idx = 0;
    logic       in_bit = 1'b0;
    logic       hold_arm = 1'b0;
    int         hold_bit = 0;
    int         hold_ticks = 0;
    int         hold_left = 0;
    int         cur_spam = 0;
    vec_t       exp_q[$];
    vec_t       tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] cmd, input logic [7:0] wr, input logic rack,
                                input logic [7:0] sbyte, input logic sack, input int spam,
                                input logic [7:0] exp_rd, input logic exp_ack, input int exp_ticks,
                                input logic exp_scl, input logic exp_sda);
        vec_t v;
        v.cmd = cmd; v.wr = wr; v.rack = rack; v.sbyte = sbyte; v.sack = sack;
        v.spam = spam; v.hold_bit = 0; v.hold_ticks = 0;
        v.exp_rd = exp_rd; v.exp_ack = exp_ack; v.exp_tmo = 1'b0; v.exp_ticks = exp_ticks;
        v.exp_scl = exp_scl; v.exp_sda = exp_sda;
        return v;
    endfunction

    function automatic logic [8:0] exp_bits(input vec_t v);
        if (v.cmd == I2C_CMD_WRITE) return {~v.wr, 1'b0};
        return {8'h00, ~v.rack};
    endfunction

    // One clock: observe at the falling edge, then present the next tick.
    task automatic step();
        @(negedge clk);
        if (tick) begin
            if (counting) tick_cnt++;
            if (hold_scl && hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) hold_scl = 1'b0;
            end
        end
        if (bus.done) done_cnt++;
        if (prev_scl && !bus.scl_oe) begin
            if (rise_cnt < 9) mbits[8 - rise_cnt] = bus.sda_oe;
            if (hold_arm && rise_cnt == hold_bit) begin
                hold_scl  = 1'b1;
                hold_left = hold_ticks;
                hold_arm  = 1'b0;
            end
            rise_cnt++;
        end
        if (!prev_scl && bus.scl_oe) slave_idx = rise_cnt;
        if (bus.sda_oe != prev_sda) last_edge_scl = bus.scl_oe;
        prev_scl  = bus.scl_oe;
        prev_sda  = bus.sda_oe;
        slave_sda = (in_bit && slave_idx < 9) ? sbits[8 - slave_idx] : 1'b1;
        tick      = (tphase == 3);
        tphase    = (tphase + 1) % 4;
    endtask

    task automatic issue(input vec_t v);
        int guard = 0;
        while (!bus.cmd_ready && guard < 400) begin
            step();
            guard++;
        end
        chk("ready_before_issue", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd       = v.cmd;
        bus.wr_data   = v.wr;
        bus.rd_ack_in = v.rack;
        in_bit        = (v.cmd == I2C_CMD_WRITE) || (v.cmd == I2C_CMD_READ);
        if (v.cmd == I2C_CMD_WRITE)     sbits = {8'hFF, v.sack};
        else if (v.cmd == I2C_CMD_READ) sbits = {v.sbyte, 1'b1};
        else                            sbits = 9'h1FF;
        rise_cnt      = 0;
        slave_idx     = 0;
        slave_sda     = in_bit ? sbits[8] : 1'b1;
        mbits         = '0;
        last_edge_scl = 1'b1;
        hold_arm      = (v.hold_ticks != 0);
        hold_bit      = v.hold_bit;
        hold_ticks    = v.hold_ticks;
        cur_spam      = v.spam;
        exp_q.push_back(v);
        step();
        bus.cmd_valid = 1'b0;
        chk("accept_busy", 32'(bus.busy), 32'd1);
        chk("accept_not_ready", 32'(bus.cmd_ready), 32'd0);
        tick_cnt  = 0;
        counting  = 1'b1;
        done_base = done_cnt;
    endtask

    task automatic wait_done(input int limit);
        vec_t e;
        int   n = 0;
        logic got = 1'b0;
        while (!got && n < limit) begin
            step();
            n++;
            if (cur_spam != 0 && n >= 3 && n < 20) begin
                bus.cmd_valid = 1'b1;
                bus.cmd       = I2C_CMD_STOP;
                bus.wr_data   = 8'h77;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (bus.done) got = 1'b1;
        end
        bus.cmd_valid = 1'b0;
        counting      = 1'b0;
        hold_scl      = 1'b0;
        hold_arm      = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_wait: no done within %0d cycles", limit);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        chk("tick_count", 32'(tick_cnt), 32'(e.exp_ticks));
        chk("ready_with_done", 32'(bus.cmd_ready), 32'd1);
        chk("timeout_err", 32'(bus.timeout_err), 32'(e.exp_tmo));
        chk("rd_data", 32'(bus.rd_data), 32'(e.exp_rd));
        chk("ack_out", 32'(bus.ack_out), 32'(e.exp_ack));
        chk("scl_oe_final", 32'(bus.scl_oe), 32'(e.exp_scl));
        chk("sda_oe_final", 32'(bus.sda_oe), 32'(e.exp_sda));
        if ((e.cmd == I2C_CMD_WRITE || e.cmd == I2C_CMD_READ) && !e.exp_tmo)
            chk("sda_bits", 32'(mbits), 32'(exp_bits(e)));
        if ((e.cmd == I2C_CMD_START || e.cmd == I2C_CMD_STOP) && !e.exp_tmo)
            chk("sda_edge_scl_released", 32'(last_edge_scl), 32'd0);
        repeat (3) step();
        chk("single_done", 32'(done_cnt - done_base), 32'd1);
        chk("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int guard;
        vec_t v;
        bus.cmd_valid = 1'b0;
        bus.cmd       = I2C_CMD_START;
        bus.wr_data   = 8'h00;
        bus.rd_ack_in = 1'b1;

        //          cmd            wr     rack  sbyte  sack spam exp_rd exp_ack ticks scl  sda
        tbl[0] = mk(I2C_CMD_START, 8'h00, 1'b1, 8'h00, 1'b1, 0, 8'h00, 1'b1,  4, 1'b1, 1'b1);
        tbl[1] = mk(I2C_CMD_WRITE, 8'hA5, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0, 36, 1'b1, 1'b0);
        tbl[2] = mk(I2C_CMD_READ,  8'h00, 1'b1, 8'h3C, 1'b1, 0, 8'h3C, 1'b0, 36, 1'b1, 1'b0);
        tbl[3] = mk(I2C_CMD_WRITE, 8'h5A, 1'b1, 8'h00, 1'b1, 0, 8'h3C, 1'b1, 36, 1'b1, 1'b0);
        tbl[4] = mk(I2C_CMD_READ,  8'h00, 1'b0, 8'hC3, 1'b1, 0, 8'hC3, 1'b1, 36, 1'b1, 1'b1);
        tbl[5] = mk(I2C_CMD_STOP,  8'h00, 1'b1, 8'h00, 1'b1, 0, 8'hC3, 1'b1,  4, 1'b0, 1'b0);
        tbl[6] = mk(I2C_CMD_START, 8'h00, 1'b1, 8'h00, 1'b1, 0, 8'hC3, 1'b1,  4, 1'b1, 1'b1);
        tbl[7] = mk(I2C_CMD_WRITE, 8'h00, 1'b1, 8'h00, 1'b0, 1, 8'hC3, 1'b0, 36, 1'b1, 1'b0);
        tbl[8] = mk(I2C_CMD_READ,  8'h00, 1'b1, 8'hFF, 1'b1, 0, 8'hFF, 1'b0, 36, 1'b1, 1'b0);
        tbl[9] = mk(I2C_CMD_STOP,  8'h00, 1'b1, 8'h00, 1'b1, 0, 8'hFF, 1'b0,  4, 1'b0, 1'b0);

        reset = 1'b1;
        repeat (3) step();
        chk("reset_scl_oe", 32'(bus.scl_oe), 32'd0);
        chk("reset_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("reset_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
        chk("reset_ack_out", 32'(bus.ack_out), 32'd1);
        reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i]);
            wait_done(400);
        end

        // Reset in the middle of a WRITE: bus released without STOP.
        issue(mk(I2C_CMD_WRITE, 8'h96, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b1, 36, 1'b1, 1'b0));
        guard = 0;
        while (slave_idx < 3 && guard < 400) begin
            step();
            guard++;
        end
        chk("midwrite_reached_bit3", 32'(slave_idx), 32'd3);
        chk("midwrite_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        step();
        chk("midrst_scl_oe", 32'(bus.scl_oe), 32'd0);
        chk("midrst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("midrst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("midrst_ack_out", 32'(bus.ack_out), 32'd1);
        reset    = 1'b0;
        counting = 1'b0;
        in_bit   = 1'b0;
        exp_q.delete();
        step();

        issue(mk(I2C_CMD_START, 8'h00, 1'b1, 8'h00, 1'b1, 0, 8'h00, 1'b1, 4, 1'b1, 1'b1));
        wait_done(400);

`ifdef CLK_STRETCH_EN
        // Slave stretches SCL for 5 ticks in bit 2, then a STOP that never
        // sees SCL released and must time out.
        v = mk(I2C_CMD_WRITE, 8'hA5, 1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0, 41, 1'b1, 1'b0);
        v.hold_bit   = 2;
        v.hold_ticks = 5;
        issue(v);
        wait_done(600);
        v = mk(I2C_CMD_STOP, 8'h00, 1'b1, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1025, 1'b0, 1'b0);
        v.hold_bit   = 0;
        v.hold_ticks = -1;
        v.exp_tmo    = 1'b1;
        issue(v);
        wait_done(5000);
`else
        v = mk(I2C_CMD_STOP, 8'h00, 1'b1, 8'h00, 1'b1, 0, 8'h00, 1'b1, 4, 1'b0, 1'b0);
        issue(v);
        wait_done(400);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
